// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token code words and the receiver alignment FSM encoding.
package tmds_pkg;

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = 2;

  // Control tokens indexed by {C1,C0}
  localparam logic [WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [STATE_W-1:0] ST_SEARCH = 2'd0;
  localparam logic [STATE_W-1:0] ST_SLIP   = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 2'd2;
  localparam logic [STATE_W-1:0] ST_LOCKED = 2'd3;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word classifier: control-token detection and 8b data recovery.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              is_ctrl_c,
  output logic [1:0]        ctrl_c,
  output logic [BYTE_W-1:0] data_c
);

  logic [BYTE_W-1:0] q;

  always_comb begin
    is_ctrl_c = 1'b1;
    ctrl_c    = 2'b00;
    case (word)
      CTRL_TOKEN_00: ctrl_c = 2'b00;
      CTRL_TOKEN_01: ctrl_c = 2'b01;
      CTRL_TOKEN_10: ctrl_c = 2'b10;
      CTRL_TOKEN_11: ctrl_c = 2'b11;
      default:       is_ctrl_c = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    q      = word[9] ? ~word[7:0] : word[7:0];
    data_c = '0;
    data_c[0] = q[0];
    for (int i = 1; i < BYTE_W; i++) begin
      data_c[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: word-boundary alignment via bitslip plus registered pixel/control decode.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned TOKEN_RUN  = 8,
  parameter int unsigned SEARCH_LEN = 2048,
  parameter int unsigned SLIP_WAIT  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [WORD_W-1:0]   data_i,
  output logic                bitslip_o,
  output logic                aligned_o,
  output logic                de_o,
  output logic [BYTE_W-1:0]   data_o,
  output logic [1:0]          ctrl_o
);

  localparam int unsigned RUN_W  = $clog2(TOKEN_RUN) + 1;
  localparam int unsigned WIN_W  = $clog2(SEARCH_LEN) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(TOKEN_RUN);
  localparam logic [WIN_W-1:0]  WIN_MAX   = WIN_W'(SEARCH_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(SLIP_WAIT - 1);

  logic                is_ctrl_c;
  logic [1:0]          dec_ctrl_c;
  logic [BYTE_W-1:0]   dec_data_c;

  logic [STATE_W-1:0]  state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [WIN_W-1:0]    win_cnt, win_nxt;
  logic [WIN_W-1:0]    loss_cnt, loss_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                de_nxt;
  logic [BYTE_W-1:0]   data_nxt;
  logic [1:0]          ctrl_nxt;

  tmds_word_decode u_word_decode (
    .word      (data_i),
    .is_ctrl_c (is_ctrl_c),
    .ctrl_c    (dec_ctrl_c),
    .data_c    (dec_data_c)
  );

  // Alignment FSM and counters, next-state
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    win_nxt   = win_cnt;
    loss_nxt  = loss_cnt;
    wait_nxt  = wait_cnt;

    case (state)
      ST_SEARCH: begin
        if (!is_ctrl_c) begin
          run_nxt = '0;
        end else if (run_cnt != RUN_LIMIT) begin
          run_nxt = run_cnt + RUN_W'(1);
        end
        if (win_cnt != WIN_MAX) begin
          win_nxt = win_cnt + WIN_W'(1);
        end
        // A completed token run wins over window expiry
        if (run_nxt == RUN_LIMIT) begin
          state_nxt = ST_LOCKED;
          run_nxt   = '0;
          win_nxt   = '0;
          loss_nxt  = '0;
        end else if (win_cnt == WIN_MAX) begin
          state_nxt = ST_SLIP;
          run_nxt   = '0;
          win_nxt   = '0;
        end
      end
      ST_SLIP: begin
        state_nxt = ST_WAIT;
        wait_nxt  = '0;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_MAX) begin
          state_nxt = ST_SEARCH;
          wait_nxt  = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_ctrl_c) begin
          loss_nxt = '0;
        end else if (loss_cnt == WIN_MAX) begin
          state_nxt = ST_SEARCH;
          loss_nxt  = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          loss_nxt = loss_cnt + WIN_W'(1);
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        run_nxt   = '0;
        win_nxt   = '0;
        loss_nxt  = '0;
        wait_nxt  = '0;
      end
    endcase

    de_nxt   = aligned_o && !is_ctrl_c;
    data_nxt = de_nxt ? dec_data_c : data_o;
    ctrl_nxt = is_ctrl_c ? dec_ctrl_c : ctrl_o;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_SEARCH;
      run_cnt   <= '0;
      win_cnt   <= '0;
      loss_cnt  <= '0;
      wait_cnt  <= '0;
      bitslip_o <= 1'b0;
      aligned_o <= 1'b0;
      de_o      <= 1'b0;
      data_o    <= '0;
      ctrl_o    <= 2'b00;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_nxt;
      win_cnt   <= win_nxt;
      loss_cnt  <= loss_nxt;
      wait_cnt  <= wait_nxt;
      bitslip_o <= (state_nxt == ST_SLIP);
      aligned_o <= (state_nxt == ST_LOCKED);
      de_o      <= de_nxt;
      data_o    <= data_nxt;
      ctrl_o    <= ctrl_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: alignment, bitslip search, loss of lock and reset abort.
module tb_tmds_decoder;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic       clk_i;
  logic       rst_n_i;
  logic [9:0] data_i;
  logic       bitslip_o;
  logic       aligned_o;
  logic       de_o;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  tmds_decoder #(
    .TOKEN_RUN  (8),
    .SEARCH_LEN (2048),
    .SLIP_WAIT  (16)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data_i    (data_i),
    .bitslip_o (bitslip_o),
    .aligned_o (aligned_o),
    .de_o      (de_o),
    .data_o    (data_o),
    .ctrl_o    (ctrl_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
  endfunction

  // Reference DVI data encoder (transition-minimising stage plus optional inversion)
  function automatic logic [9:0] encode(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    int n1;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [9:0] t;
    t = w;
    for (int i = 0; i < r; i++) t = {t[8:0], t[9]};
    return t;
  endfunction

  // Drive one word at a falling edge; outputs are sampled at the next falling edge
  task automatic cycle(input logic [9:0] w);
    data_i = w;
    @(negedge clk_i);
  endtask

  task automatic do_reset;
    rst_n_i = 1'b0;
    data_i  = '0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    data_i  = TOK3;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({bitslip_o, aligned_o, de_o, data_o, ctrl_o} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want all zero", {bitslip_o, aligned_o, de_o, data_o, ctrl_o});
    end
    rst_n_i = 1'b1;
  endtask

  task automatic test_align;
    int slips;
    do_reset();
    slips = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(TOK0);
      if (bitslip_o) slips++;
      if (i == 6) begin
        checks++;
        if (aligned_o !== 1'b0) begin
          failures++;
          $display("FAIL align_early: aligned_o=%b after 7 tokens want 0", aligned_o);
        end
      end
    end
    checks++;
    if (aligned_o !== 1'b1) begin
      failures++;
      $display("FAIL align_after_8: aligned_o=%b want 1", aligned_o);
    end
    checks++;
    if (ctrl_o !== 2'b00) begin
      failures++;
      $display("FAIL align_ctrl: ctrl_o=%b want 00", ctrl_o);
    end
    checks++;
    if (slips != 0) begin
      failures++;
      $display("FAIL align_no_slip: %0d bitslip pulses want 0", slips);
    end
  endtask

  task automatic test_data;
    logic [7:0] b;
    logic [7:0] exp;
    logic [7:0] last;
    logic [9:0] w;
    logic       inv;
    last = 8'h00;
    for (int i = 0; i < 7; i++) begin
      b   = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      inv = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      w   = encode(b, inv);
      if (is_token(w)) w = encode(b, ~inv);
      exp_q.push_back(b);
      cycle(w);
      checks++;
      if (de_o !== 1'b1) begin
        failures++;
        $display("FAIL data_de: word %0d de_o=%b want 1", i, de_o);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL data_underflow: de_o=1 with empty scoreboard");
      end else begin
        exp = exp_q.pop_front();
        if (data_o !== exp) begin
          failures++;
          $display("FAIL data_value: word %0d data_o=%h want %h", i, data_o, exp);
        end
        last = exp;
      end
    end
    cycle(TOK3);
    checks++;
    if (de_o !== 1'b0 || ctrl_o !== 2'b11) begin
      failures++;
      $display("FAIL data_token: de_o=%b ctrl_o=%b want 0/11", de_o, ctrl_o);
    end
    checks++;
    if (data_o !== last || aligned_o !== 1'b1) begin
      failures++;
      $display("FAIL data_hold: data_o=%h aligned_o=%b want %h/1", data_o, aligned_o, last);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL data_leftover: %0d entries want 0", exp_q.size());
    end
  endtask

  task automatic test_loss;
    logic [9:0] w;
    int de_bad;
    int first_pulse;
    w = encode(8'h3C, 1'b0);
    for (int k = 1; k <= 2048; k++) begin
      cycle(w);
      if (k == 2047) begin
        checks++;
        if (aligned_o !== 1'b1) begin
          failures++;
          $display("FAIL loss_early: aligned_o=%b after 2047 data words want 1", aligned_o);
        end
      end
    end
    checks++;
    if (aligned_o !== 1'b0) begin
      failures++;
      $display("FAIL loss_drop: aligned_o=%b after 2048 data words want 0", aligned_o);
    end
    de_bad = 0;
    first_pulse = 0;
    for (int j = 1; j <= 2048; j++) begin
      cycle(w);
      if (de_o !== 1'b0) de_bad++;
      if (bitslip_o && first_pulse == 0) first_pulse = j;
    end
    checks++;
    if (de_bad != 0) begin
      failures++;
      $display("FAIL loss_de: de_o high on %0d cycles want 0", de_bad);
    end
    checks++;
    if (first_pulse != 2048) begin
      failures++;
      $display("FAIL loss_slip_time: first bitslip at cycle %0d want 2048", first_pulse);
    end
  endtask

  task automatic test_slip;
    int rot;
    int pulses;
    int p[3];
    int aligned_at;
    do_reset();
    rot = 3;
    pulses = 0;
    aligned_at = 0;
    p[0] = 0; p[1] = 0; p[2] = 0;
    for (int n = 1; n <= 9000; n++) begin
      cycle(rotl(TOK0, rot));
      if (bitslip_o) begin
        if (pulses < 3) p[pulses] = n;
        pulses++;
        if (rot > 0) rot--;
      end
      if (aligned_o) begin
        aligned_at = n;
        break;
      end
    end
    checks++;
    if (aligned_at == 0) begin
      failures++;
      $display("FAIL slip_lock_timeout: aligned_o never rose, pulses=%0d", pulses);
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL slip_count: %0d pulses want 3", pulses);
    end
    checks++;
    if (p[0] != 2048 || p[1] - p[0] != 2065 || p[2] - p[1] != 2065) begin
      failures++;
      $display("FAIL slip_spacing: pulses at %0d %0d %0d want 2048 4113 6178", p[0], p[1], p[2]);
    end
    checks++;
    if (aligned_at - p[2] != 25) begin
      failures++;
      $display("FAIL slip_relock: aligned %0d cycles after last pulse want 25", aligned_at - p[2]);
    end
  endtask

  task automatic test_break_reset;
    int bad;
    int found;
    logic [9:0] w;
    do_reset();
    w = encode(8'h00, 1'b0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cycle((i == 7) ? w : TOK2);
      if (aligned_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL break_run: aligned_o high on %0d cycles want 0", bad);
    end
    checks++;
    if (ctrl_o !== 2'b10) begin
      failures++;
      $display("FAIL break_ctrl: ctrl_o=%b want 10", ctrl_o);
    end
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle(w);
      if (bitslip_o) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL break_slip_timeout: no bitslip within 3000 cycles");
    end
    repeat (5) cycle(w);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({bitslip_o, aligned_o, de_o, data_o, ctrl_o} !== 13'h0) begin
      failures++;
      $display("FAIL wait_reset_async: got %b want all zero", {bitslip_o, aligned_o, de_o, data_o, ctrl_o});
    end
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(w);
      if (bitslip_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wait_reset_pulse: %0d bitslip pulses after reset want 0", bad);
    end
    repeat (8) cycle(TOK0);
    checks++;
    if (aligned_o !== 1'b1) begin
      failures++;
      $display("FAIL wait_reset_relock: aligned_o=%b want 1", aligned_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n_i  = 1'b0;
    data_i   = '0;
    test_reset();
    test_align();
    test_data();
    test_loss();
    test_slip();
    test_break_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter TOKEN_RUN, default 8: consecutive control tokens required to declare alignment.
REQ-002 SHALL have parameter SEARCH_LEN, default 2048: cycles without a qualifying token run (SEARCH) or without any token (LOCKED) before realignment action.
REQ-003 SHALL have parameter SLIP_WAIT, default 16: settle cycles after each bitslip pulse.
REQ-004 SHALL have port clk_i, input, 1: pixel clock; the block's single clock domain.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port data_i, input, 10: deserialized TMDS word, bit 0 first on the wire, one word per clk_i.
REQ-007 SHALL have port bitslip_o, output, 1: one-cycle request to the deserializer to shift the word boundary by one bit.
REQ-008 SHALL have port aligned_o, output, 1: word boundary locked.
REQ-009 SHALL have port de_o, output, 1: decoded video data valid (active area).
REQ-010 SHALL have port data_o, output, 8: decoded pixel byte.
REQ-011 SHALL have port ctrl_o, output, 2: last received control token {C1,C0}.

Function
REQ-012 SHALL classify data_i as control tokens: 10'b1101010100->00, 10'b0010101011->01, 10'b0101010100->10, 10'b1010101011->11; any other word is a data word.
REQ-013 SHALL decode data words as: q = data_i[9] ? ~data_i[7:0] : data_i[7:0]; d[0]=q[0]; d[i]=q[i]^q[i-1] when data_i[8]=1, else ~(q[i]^q[i-1]), for i=1..7.
REQ-014 SHALL register data_o, de_o and ctrl_o with exactly 1 clk_i latency from data_i.
REQ-015 SHALL drive de_o=1 only for a data word while aligned_o=1; otherwise de_o=0.
REQ-016 SHALL update data_o only when de_o is asserted; otherwise data_o holds.
REQ-017 SHALL update ctrl_o on every control token, regardless of alignment, and hold it during data words.
REQ-018 SHALL implement FSM states SEARCH, SLIP, WAIT, LOCKED.
REQ-019 In SEARCH, SHALL count consecutive control tokens (count cleared by any data word) and increment a window counter every cycle.
REQ-020 SEARCH->LOCKED SHALL occur when the run count reaches TOKEN_RUN; this transition takes priority over window expiry in the same cycle.
REQ-021 SEARCH->SLIP SHALL occur when the window counter reaches SEARCH_LEN-1 without a qualifying run.
REQ-022 SLIP SHALL assert bitslip_o for exactly one cycle, then go to WAIT; bitslip_o SHALL be 0 in all other states.
REQ-023 WAIT SHALL last SLIP_WAIT cycles, ignoring data_i, then enter SEARCH with the run and window counters cleared.
REQ-024 In LOCKED, aligned_o SHALL be 1; the loss timer SHALL clear on every control token.
REQ-025 LOCKED->SEARCH SHALL occur when the loss timer reaches SEARCH_LEN-1; aligned_o SHALL drop in that same registered update.
REQ-026 Counters SHALL saturate and never wrap; widths SHALL be $clog2 of their limit plus 1.
REQ-027 The block SHALL slip indefinitely while no token runs are present; it SHALL NOT count or limit the number of slips.

Reset
REQ-028 rst_n_i low SHALL asynchronously force state SEARCH, all counters 0, bitslip_o=0, aligned_o=0, de_o=0, data_o=8'h00, ctrl_o=2'b00.
REQ-029 Reset asserted mid-SLIP or mid-WAIT SHALL abort without emitting a further bitslip_o pulse; after release the block SHALL restart from SEARCH.

Structure
REQ-030 The four control-token constants and the FSM state encoding SHALL reside in a shared package, tmds_pkg, reused by the encoder side.
REQ-031 The word decode of REQ-012/REQ-013 SHALL be a combinational sub-module, tmds_word_decode; the FSM and output registers SHALL remain in tmds_decoder.

Verification
REQ-032 Reset release, then 8 consecutive 10'b1101010100 words -> aligned_o=1 on the cycle after the 8th word; ctrl_o=00; bitslip_o never asserted.
REQ-033 While locked, feed the encoder output for byte 8'hA5 -> de_o=1 and data_o=8'hA5 one cycle later; feed token 10'b1010101011 -> de_o=0 and ctrl_o=11.
REQ-034 Feed a token stream rotated by 3 bits, with the model rotating back one bit per bitslip_o pulse -> exactly 3 pulses, spaced 2048+1+16 cycles apart, then aligned_o=1.
REQ-035 While locked, feed 2048 data-only cycles -> aligned_o=0 after the 2048th; de_o=0 thereafter; no bitslip_o until a further 2048 tokenless cycles.
REQ-036 Feed 7 tokens, 1 data word, then 7 tokens -> aligned_o stays 0; assert rst_n_i low during WAIT -> all outputs 0 immediately and no bitslip_o pulse follows.
